// File: rtl/ctech_lib_sync_deglitch.sv
// Per-bit deglitch filter with registered level, edge and glitch outputs.
// Sits directly behind the set-type triple synchronizer.
module ctech_lib_sync_deglitch #(
   parameter int unsigned WIDTH         = 1,
   parameter int unsigned FILTER_CYCLES = 3,
   parameter logic        RESET_VAL     = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] glitch
);

   localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
      $error("FILTER_CYCLES must be in 1..255");
   end

   typedef enum logic {
      STABLE  = 1'b0,
      QUALIFY = 1'b1
   } state_t;

   state_t           st_q   [WIDTH];
   state_t           st_d   [WIDTH];
   logic [CW-1:0]    cnt_q  [WIDTH];
   logic [CW-1:0]    cnt_d  [WIDTH];
   logic [WIDTH-1:0] o_d;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_d;
   logic [WIDTH-1:0] glitch_d;

   // Next-state and pulse decode for every bit; en=0 holds all state.
   always_comb begin
      o_d      = o;
      rise_d   = '0;
      fall_d   = '0;
      glitch_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         if (en) begin
            unique case (st_q[i])
               STABLE: begin
                  if (d[i] != o[i]) begin
                     if (FILTER_CYCLES == 1) begin
                        o_d[i]    = d[i];
                        rise_d[i] = d[i];
                        fall_d[i] = ~d[i];
                     end else begin
                        st_d[i]  = QUALIFY;
                        cnt_d[i] = ONE;
                     end
                  end
               end
               QUALIFY: begin
                  if (d[i] != o[i]) begin
                     if (cnt_q[i] == LAST) begin
                        o_d[i]    = d[i];
                        rise_d[i] = d[i];
                        fall_d[i] = ~d[i];
                        cnt_d[i]  = '0;
                        st_d[i]   = STABLE;
                     end else begin
                        cnt_d[i] = cnt_q[i] + ONE;
                     end
                  end else begin
                     glitch_d[i] = 1'b1;
                     cnt_d[i]    = '0;
                     st_d[i]     = STABLE;
                  end
               end
               default: begin
                  st_d[i]  = STABLE;
                  cnt_d[i] = '0;
               end
            endcase
         end
      end
   end

   // State, level and pulse registers; reset aborts any pending change.
   always_ff @(posedge clk) begin
      if (rst) begin
         o      <= {WIDTH{RESET_VAL}};
         rise   <= '0;
         fall   <= '0;
         glitch <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            st_q[i]  <= STABLE;
            cnt_q[i] <= '0;
         end
      end else begin
         o      <= o_d;
         rise   <= rise_d;
         fall   <= fall_d;
         glitch <= glitch_d;
         for (int i = 0; i < WIDTH; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_ctech_lib_sync_deglitch.sv
// Bench for ctech_lib_sync_deglitch: 4-bit/3-cycle and 1-bit/1-cycle filters.
// Expected outputs come from a run-length reference model via a queue.
module tb_ctech_lib_sync_deglitch;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] d;
   logic [3:0] o, rise, fall, glitch;
   logic [0:0] d1;
   logic [0:0] o1, rise1, fall1, glitch1;

   int compared = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [3:0] o, ri, fa, gl;
      logic       o1, ri1, fa1, gl1;
   } exp_t;

   exp_t       q[$];
   logic [3:0] mo;
   int         mr[4];
   logic       mo1;
   int         mr1;

   always #5 clk = ~clk;

   ctech_lib_sync_deglitch #(
      .WIDTH(4), .FILTER_CYCLES(3), .RESET_VAL(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .d(d), .en(en),
      .o(o), .rise(rise), .fall(fall), .glitch(glitch)
   );

   ctech_lib_sync_deglitch #(
      .WIDTH(1), .FILTER_CYCLES(1), .RESET_VAL(1'b0)
   ) dut1 (
      .clk(clk), .rst(rst), .d(d1), .en(en),
      .o(o1), .rise(rise1), .fall(fall1), .glitch(glitch1)
   );

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: count consecutive enabled samples that differ from the level.
   task automatic model_bit(input int f, input logic rv, input logic r_i,
                            input logic en_i, input logic d_i,
                            inout logic lvl, inout int run,
                            output logic ri, output logic fa, output logic gl);
      ri = 1'b0; fa = 1'b0; gl = 1'b0;
      if (r_i) begin
         lvl = rv;
         run = 0;
      end else if (en_i) begin
         if (d_i !== lvl) begin
            run = run + 1;
            if (run >= f) begin
               ri  = d_i;
               fa  = ~d_i;
               lvl = d_i;
               run = 0;
            end
         end else if (run > 0) begin
            gl  = 1'b1;
            run = 0;
         end
      end
   endtask

   task automatic step(input string tag, input logic r_v, input logic en_v,
                       input logic [3:0] d_v, input logic d1_v);
      exp_t e;
      rst = r_v; en = en_v; d = d_v; d1 = d1_v;
      for (int i = 0; i < 4; i++) begin
         logic lv;
         int   rn;
         lv = mo[i];
         rn = mr[i];
         model_bit(3, 1'b1, r_v, en_v, d_v[i], lv, rn,
                   e.ri[i], e.fa[i], e.gl[i]);
         mo[i] = lv;
         mr[i] = rn;
      end
      e.o = mo;
      model_bit(1, 1'b0, r_v, en_v, d1_v, mo1, mr1, e.ri1, e.fa1, e.gl1);
      e.o1 = mo1;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk({tag, ".o"}, o, e.o);
      chk({tag, ".rise"}, rise, e.ri);
      chk({tag, ".fall"}, fall, e.fa);
      chk({tag, ".glitch"}, glitch, e.gl);
      chk({tag, ".o1"}, {3'b0, o1}, {3'b0, e.o1});
      chk({tag, ".rise1"}, {3'b0, rise1}, {3'b0, e.ri1});
      chk({tag, ".fall1"}, {3'b0, fall1}, {3'b0, e.fa1});
      chk({tag, ".glitch1"}, {3'b0, glitch1}, {3'b0, e.gl1});
   endtask

   logic t;

   initial begin
      rst = 1'b1; en = 1'b0; d = 4'h0; d1 = 1'b0;
      mo = 4'hF; mo1 = 1'b0; mr1 = 0;
      for (int i = 0; i < 4; i++) mr[i] = 0;
      t = 1'b0;

      step("rst", 1'b1, 1'b0, 4'h0, 1'b1);
      step("rst", 1'b1, 1'b0, 4'h0, 1'b1);
      chk("rst_o_const", o, 4'hF);
      chk("rst_pulse_const", rise | fall | glitch, 4'h0);

      // Quiet start, then a clean fall on bit 0; dut1 toggles every step.
      for (int k = 0; k < 2; k++) begin t = ~t; step("idle", 1'b0, 1'b1, 4'hF, t); end
      t = ~t; step("fall_a", 1'b0, 1'b1, 4'hE, t);
      t = ~t; step("fall_b", 1'b0, 1'b1, 4'hE, t);
      chk("fall_pre_const", o, 4'hF);
      t = ~t; step("fall_c", 1'b0, 1'b1, 4'hE, t);
      chk("fall_edge_const", fall, 4'h1);
      chk("fall_o_const", o, 4'hE);
      t = ~t; step("fall_d", 1'b0, 1'b1, 4'hE, t);
      chk("fall_clear_const", fall, 4'h0);

      // Two-sample excursion on bit 0 is rejected.
      t = ~t; step("gl_a", 1'b0, 1'b1, 4'hF, t);
      t = ~t; step("gl_b", 1'b0, 1'b1, 4'hF, t);
      t = ~t; step("gl_c", 1'b0, 1'b1, 4'hE, t);
      chk("gl_pulse_const", glitch, 4'h1);
      chk("gl_o_const", o, 4'hE);
      t = ~t; step("gl_d", 1'b0, 1'b1, 4'hE, t);

      // Freeze mid-qualify; d noise while frozen must be ignored.
      t = ~t; step("frz_a", 1'b0, 1'b1, 4'hF, t);
      t = ~t; step("frz_b", 1'b0, 1'b1, 4'hF, t);
      step("frz_0", 1'b0, 1'b0, 4'hE, t);
      step("frz_1", 1'b0, 1'b0, 4'h0, t);
      step("frz_2", 1'b0, 1'b0, 4'hE, t);
      chk("frz_hold_const", o, 4'hE);
      t = ~t; step("frz_c", 1'b0, 1'b1, 4'hF, t);
      chk("frz_rise_const", rise, 4'h1);

      // Pulse followed by en drop still clears.
      step("pulse_en0", 1'b0, 1'b0, 4'hF, t);

      // Reset in the middle of a bit-3 fall.
      t = ~t; step("rmq_a", 1'b0, 1'b1, 4'h7, t);
      t = ~t; step("rmq_b", 1'b0, 1'b1, 4'h7, t);
      step("rmq_rst", 1'b1, 1'b1, 4'h7, t);
      chk("rmq_o_const", o, 4'hF);
      for (int k = 0; k < 3; k++) begin
         t = ~t; step("rmq_post", 1'b0, 1'b1, 4'h7, t);
      end
      chk("rmq_fall_const", fall, 4'h8);

      // Multi-bit: settle to 0101, then rise on 3,1 and glitch on 2,0.
      for (int k = 0; k < 4; k++) begin
         t = ~t; step("mb_set", 1'b0, 1'b1, 4'h5, t);
      end
      chk("mb_pre_const", o, 4'h5);
      t = ~t; step("mb_a", 1'b0, 1'b1, 4'hA, t);
      t = ~t; step("mb_b", 1'b0, 1'b1, 4'hF, t);
      chk("mb_glitch_const", glitch, 4'h5);
      t = ~t; step("mb_c", 1'b0, 1'b1, 4'hF, t);
      chk("mb_rise_const", rise, 4'hA);
      chk("mb_post_const", o, 4'hF);

      // Random traffic with occasional freeze and reset.
      for (int k = 0; k < 200; k++) begin
         logic [3:0] dr;
         logic       er, rr;
         dr = 4'($urandom_range(0, 15));
         er = ($urandom_range(0, 7) != 0);
         rr = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 2) != 0) dr = mo ^ (dr & 4'($urandom_range(0, 15)));
         step("rand", rr, er, dr, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
